// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit.
package hazard_control_unit_pkg;

    localparam int HCU_REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hcu_state_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: tracks ID/EX, EX/MEM, MEM/WB destination info and
// generates stall / flush / freeze controls plus performance counters.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_W = HCU_REG_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regWrite,
    input  logic                  id_memRead,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [REG_ADDR_W-1:0] id_ex_rs1,
    output logic [REG_ADDR_W-1:0] id_ex_rs2,
    output logic [REG_ADDR_W-1:0] id_ex_rd,
    output logic [REG_ADDR_W-1:0] ex_mem_rd,
    output logic [REG_ADDR_W-1:0] mem_wb_rd,
    output logic                  id_ex_memRead,
    output logic                  ex_mem_regWrite,
    output logic                  mem_wb_regWrite,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } id_ex_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } late_stage_t;

    hcu_state_e  state_q, state_d;
    id_ex_t      id_ex_q, id_ex_d;
    late_stage_t ex_mem_q, ex_mem_d;
    late_stage_t mem_wb_q, mem_wb_d;
    logic        load_use;
    logic        stall_inc;
    logic        flush_inc;

    // The bubble left behind by a load-use stall can never itself raise a
    // hazard, so LU_STALL always lasts a single cycle.
    always_comb begin
        load_use = id_valid && id_ex_q.valid && id_ex_q.mem_read
                && (id_ex_q.rd != '0)
                && ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2))
                && (state_q != ST_LU_STALL);
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = ST_RUN;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        id_ex_d      = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                         reg_write: id_regWrite, mem_read: id_memRead};
        ex_mem_d     = '{valid: id_ex_q.valid, rd: id_ex_q.rd,
                         reg_write: id_ex_q.reg_write};
        mem_wb_d     = ex_mem_q;

        if (rst) begin
            // Registers are cleared by the flops; controls stay at their run values.
            state_d = ST_RUN;
        end else if (!dmem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_d     = id_ex_q;
            ex_mem_d    = ex_mem_q;
            mem_wb_d    = mem_wb_q;
            state_d     = ST_MEM_WAIT;
            stall_inc   = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            id_ex_d      = '0;
            flush_inc    = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            id_ex_d      = '0;
            state_d      = ST_LU_STALL;
            stall_inc    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            state_q  <= state_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign id_ex_rs1       = id_ex_q.rs1;
    assign id_ex_rs2       = id_ex_q.rs2;
    assign id_ex_rd        = id_ex_q.rd;
    assign ex_mem_rd       = ex_mem_q.rd;
    assign mem_wb_rd       = mem_wb_q.rd;
    assign id_ex_memRead   = id_ex_q.mem_read;
    assign ex_mem_regWrite = ex_mem_q.valid && ex_mem_q.reg_write;
    assign mem_wb_regWrite = mem_wb_q.valid && mem_wb_q.reg_write;

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: driver pushes model predictions, monitor pops and compares.
module tb_hazard_control_unit;

    localparam int AW   = 5;
    localparam int CW   = 16;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic          id_regWrite = 1'b0, id_memRead = 1'b0;
    logic          ex_branch_taken = 1'b0, dmem_ready = 1'b1;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [AW-1:0] id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic          id_ex_memRead, ex_mem_regWrite, mem_wb_regWrite;
    logic [CW-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_memRead(id_ex_memRead), .ex_mem_regWrite(ex_mem_regWrite),
        .mem_wb_regWrite(mem_wb_regWrite), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    // One in-flight instruction as the reference model sees it.
    typedef struct packed {
        bit          v;
        bit [AW-1:0] rs1;
        bit [AW-1:0] rs2;
        bit [AW-1:0] rd;
        bit          rw;
        bit          mr;
    } instr_t;

    typedef struct {
        bit          pcw, ifw, fl, bub;
        bit          chk_regs;
        bit [AW-1:0] ir1, ir2, ird, emrd, mwrd;
        bit          imr, emrw, mwrw;
        int          sc, fe;
    } exp_t;

    exp_t   exp_q[$];
    instr_t m_stage[3];
    int     m_sc = 0, m_fe = 0;
    bit     m_known = 0;
    int     checks = 0, failures = 0;
    int     txn = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL txn=%0d %s actual=%0d expected=%0d", txn, name, act, expv);
        end
    endtask

    // Drive one cycle of inputs and predict this cycle's observable response.
    task automatic step(input bit r, input bit idv, input bit [AW-1:0] a, input bit [AW-1:0] b,
                        input bit [AW-1:0] d, input bit rw, input bit mr,
                        input bit br, input bit rdy);
        exp_t   e;
        instr_t incoming;
        bit     hz;
        @(negedge clk);
        rst = r; id_valid = idv; id_rs1 = a; id_rs2 = b; id_rd = d;
        id_regWrite = rw; id_memRead = mr; ex_branch_taken = br; dmem_ready = rdy;

        e.chk_regs = m_known;
        e.ir1  = m_stage[0].rs1;
        e.ir2  = m_stage[0].rs2;
        e.ird  = m_stage[0].rd;
        e.imr  = m_stage[0].mr;
        e.emrd = m_stage[1].rd;
        e.emrw = m_stage[1].v & m_stage[1].rw;
        e.mwrd = m_stage[2].rd;
        e.mwrw = m_stage[2].v & m_stage[2].rw;
        e.sc   = m_sc;
        e.fe   = m_fe;
        e.pcw = 1; e.ifw = 1; e.fl = 0; e.bub = 0;

        incoming = '{v: idv, rs1: a, rs2: b, rd: d, rw: rw, mr: mr};
        if (r) begin
            foreach (m_stage[i]) m_stage[i] = '0;
            m_sc = 0; m_fe = 0; m_known = 1;
        end else if (!rdy) begin
            e.pcw = 0; e.ifw = 0;
            m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end else begin
            hz = idv && m_stage[0].v && m_stage[0].mr && (m_stage[0].rd != 0)
                 && (m_stage[0].rd == a || m_stage[0].rd == b);
            if (br) begin
                e.fl = 1; e.bub = 1;
                incoming = '0;
                m_fe = (m_fe < CMAX) ? m_fe + 1 : CMAX;
            end else if (hz) begin
                e.pcw = 0; e.ifw = 0; e.bub = 1;
                incoming = '0;
                m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            end
            m_stage[2] = m_stage[1];
            m_stage[1] = m_stage[0];
            m_stage[0] = incoming;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle the DUT presents a response; compare against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("pc_write",     int'(pc_write),     int'(e.pcw));
                chk("if_id_write",  int'(if_id_write),  int'(e.ifw));
                chk("if_id_flush",  int'(if_id_flush),  int'(e.fl));
                chk("id_ex_bubble", int'(id_ex_bubble), int'(e.bub));
                if (e.chk_regs) begin
                    chk("id_ex_rs1",       int'(id_ex_rs1),       int'(e.ir1));
                    chk("id_ex_rs2",       int'(id_ex_rs2),       int'(e.ir2));
                    chk("id_ex_rd",        int'(id_ex_rd),        int'(e.ird));
                    chk("id_ex_memRead",   int'(id_ex_memRead),   int'(e.imr));
                    chk("ex_mem_rd",       int'(ex_mem_rd),       int'(e.emrd));
                    chk("ex_mem_regWrite", int'(ex_mem_regWrite), int'(e.emrw));
                    chk("mem_wb_rd",       int'(mem_wb_rd),       int'(e.mwrd));
                    chk("mem_wb_regWrite", int'(mem_wb_regWrite), int'(e.mwrw));
                    chk("stall_cycles",    int'(stall_cycles),    e.sc);
                    chk("flush_events",    int'(flush_events),    e.fe);
                end
            end
        end
    end

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 1, 3, 4, 5, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // lw x5 then add x6,x5,x1: one stall, then the held add proceeds
        step(0, 1, 2, 0, 5, 1, 1, 0, 1);
        step(0, 1, 5, 1, 6, 1, 0, 0, 1);
        step(0, 1, 5, 1, 6, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // load to x0 followed by an x0 consumer: no stall
        step(0, 1, 1, 0, 0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 7, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // branch together with a load-use hazard: flush only
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 2, 7, 1, 1, 0, 1);
        step(0, 1, 7, 3, 8, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // three-cycle memory freeze with a pending branch, released with it still high
        step(0, 1, 1, 2, 9, 1, 0, 0, 1);
        step(0, 1, 3, 4, 10, 1, 0, 0, 1);
        repeat (3) step(0, 1, 5, 6, 11, 1, 0, 1, 0);
        step(0, 1, 5, 6, 11, 1, 0, 1, 1);
        step(0, 1, 5, 6, 12, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // reset arriving while in the load-use stall
        step(0, 1, 1, 2, 4, 1, 1, 0, 1);
        step(0, 1, 4, 0, 6, 1, 0, 0, 1);
        step(1, 1, 4, 0, 6, 1, 0, 0, 1);
        step(0, 1, 4, 0, 6, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        // randomized traffic over a narrow register range to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(99) < 2), ($urandom_range(9) < 8),
                 AW'($urandom_range(3)), AW'($urandom_range(3)), AW'($urandom_range(3)),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(99) < 12), ($urandom_range(99) >= 15));
        end
        // counter saturation: freeze well past all-ones
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < CMAX + 5; i++) begin
            step(0, 1, 1, 1, 2, 1, 0, 1, 0);
        end
        step(0, 1, 1, 2, 3, 1, 1, 0, 1);
        step(0, 1, 3, 0, 4, 1, 0, 0, 1);
        step(0, 1, 1, 0, 4, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        #4;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-index width.
REQ-002 Parameter CNT_W, default 16: width of each performance counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2, id_rd  in  REG_ADDR_W each  ID-stage source and destination indices.
REQ-007 id_regWrite, id_memRead  in  1 each  ID-stage instruction writes rd / is a load.
REQ-008 ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
REQ-009 dmem_ready  in  1  data memory completes this cycle; low freezes the pipeline.
REQ-010 pc_write, if_id_write  out  1 each  enables for the PC and IF/ID registers.
REQ-011 if_id_flush, id_ex_bubble  out  1 each  clear IF/ID / insert a NOP into ID/EX.
REQ-012 id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd  out  REG_ADDR_W each  tracked stage indices, consumed by forwarding logic.
REQ-013 id_ex_memRead, ex_mem_regWrite, mem_wb_regWrite  out  1 each  tracked stage control bits.
REQ-014 stall_cycles, flush_events  out  CNT_W each  saturating performance counters.

Function
REQ-015 Three tracking stages shall be held: ID/EX {valid, rs1, rs2, rd, regWrite, memRead}, EX/MEM {valid, rd, regWrite}, MEM/WB {valid, rd, regWrite}.
REQ-016 Each stage's regWrite output shall be gated by that stage's valid bit.
REQ-017 The FSM shall have states RUN, LU_STALL and MEM_WAIT.
REQ-018 Priority each cycle, highest first: rst, freeze (dmem_ready=0), branch flush, load-use stall, normal advance.
REQ-019 Freeze: all tracking registers hold; pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0; state goes to MEM_WAIT.
REQ-020 MEM_WAIT shall return to RUN in the first cycle with dmem_ready=1, and that cycle shall be evaluated normally per REQ-018.
REQ-021 ex_branch_taken is ignored while frozen; it is honoured when the freeze lifts if it is still asserted.
REQ-022 Branch flush: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; ID/EX.valid is loaded as 0; EX/MEM and MEM/WB advance; flush_events increments.
REQ-023 Load-use hazard: id_valid & ID/EX.valid & ID/EX.memRead & ID/EX.rd!=0 & (ID/EX.rd==id_rs1 | ID/EX.rd==id_rs2).
REQ-024 On a load-use hazard: pc_write=0, if_id_write=0, id_ex_bubble=1; ID/EX.valid is loaded as 0; later stages advance; state goes to LU_STALL.
REQ-025 LU_STALL shall last exactly one cycle, then return to RUN; the held instruction re-evaluates with no hazard, since the load has moved to EX/MEM.
REQ-026 Normal advance: ID/EX <= {id_valid, ID fields}; EX/MEM <= ID/EX; MEM/WB <= EX/MEM; pc_write=1, if_id_write=1, flushes=0.
REQ-027 A branch flush in the same cycle as a load-use hazard shall flush only; it shall not stall and shall not enter LU_STALL.
REQ-028 stall_cycles shall increment on every freeze or load-use cycle; flush_events shall increment once per flush cycle.
REQ-029 Both counters shall saturate at all-ones and never wrap.
REQ-030 All control outputs (pc_write, if_id_write, if_id_flush, id_ex_bubble) shall be combinational from the current state and inputs; all index outputs shall be registered.

Reset
REQ-031 On rst: all valid bits 0, all indices 0, all control bits 0, counters 0, state RUN.
REQ-032 While rst is asserted, control outputs shall be pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
REQ-033 A stall or freeze in progress is abandoned by rst within the same cycle; no stale hazard survives reset.

Structure
REQ-034 The state encoding (RUN, LU_STALL, MEM_WAIT) and the REG_ADDR_W default shall live in the shared pipeline package.
REQ-035 A sub-module hazard_sat_counter (parameter CNT_W; inputs clk, rst, inc; output count) shall be instantiated twice.

Verification
REQ-036 Scenario: lw x5 in ID/EX, ID add x6,x5,x1 -> one cycle with pc_write=0 and id_ex_bubble=1; next cycle ex_mem_rd=5; stall_cycles=1.
REQ-037 Scenario: load with rd=x0 followed by a consumer of x0 -> no stall.
REQ-038 Scenario: ex_branch_taken with a load-use hazard in the same cycle -> if_id_flush=1, pc_write=1, flush_events=1, stall_cycles=0.
REQ-039 Scenario: dmem_ready low for 3 cycles -> tracked indices frozen, stall_cycles=3; on release the pipeline advances in that cycle.
REQ-040 Scenario: counters preloaded to 0xFFFF, further stalls -> counters remain 0xFFFF.
REQ-041 Scenario: rst asserted in LU_STALL -> next cycle state RUN, all regWrite outputs 0, pc_write=1.
